uart_frame_parser: RTL and testbench
====================================

Name: uart_frame_parser

Overview:
- Consumes bytes from the 16x-oversampled UART receiver (8-bit data plus read strobe) and assembles them into command frames.
- Frame format: HEADER, CMD, LEN, LEN payload bytes, CSUM.
- Validated frames are held in a payload buffer for the register/command layer, which reads them and then acknowledges.
- Runs on the same clk as the UART receiver.

Parameters:
- HEADER, 8'hA5, start-of-frame byte.
- MAX_LEN, 16, maximum payload bytes (1..255).
- TIMEOUT_CYC, 640, inter-byte timeout in clk cycles (4 byte-times at 16x).

Ports:
- clk  in  1  clock, 16x baud sample clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte, stable while rx_rdsig high.
- rx_rdsig  in  1  byte-ready level from receiver, high 1+ cycles per byte.
- frame_valid  out  1  a checked frame is held; level.
- frame_cmd  out  8  CMD of held frame.
- frame_len  out  8  LEN of held frame.
- rd_addr  in  $clog2(MAX_LEN)  payload read index.
- rd_data  out  8  payload byte, registered.
- frame_ack  in  1  consumer releases held frame.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  2  error cause, valid with err_pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, checksum 0, byte counter 0, timeout counter 0.
- Byte strobe: byte_stb = rx_rdsig rising edge (rx_rdsig & ~rx_rdsig_d). Exactly one byte accepted per strobe; the held-high level is ignored. rx_data is sampled in the byte_stb cycle.
- FSM states: IDLE, CMD, LEN, DATA, CSUM, HOLD.
- IDLE: on byte_stb with HEADER, go to CMD; any other byte is discarded silently.
- CMD: on byte_stb, latch cmd; csum = byte; go to LEN.
- LEN: on byte_stb:
  - if byte > MAX_LEN: err 2'b01, go to IDLE.
  - else latch len; csum += byte; cnt = 0; go to DATA, or to CSUM if len == 0.
- DATA: on byte_stb, write byte to buf[cnt]; csum += byte; cnt++. Go to CSUM when cnt reaches len-1.
- CSUM: on byte_stb:
  - if byte == csum: frame_valid <= 1, frame_cmd/frame_len updated, go to HOLD.
  - else err 2'b10, go to IDLE.
- Checksum arithmetic: 8-bit sum of CMD, LEN and payload, wraps mod 256. HEADER and CSUM are excluded.
- HOLD: frame_valid stays 1 until frame_ack.
  - On frame_ack: frame_valid <= 0, go to IDLE.
  - byte_stb without frame_ack in HOLD: byte dropped, err 2'b00 (overrun), frame retained.
  - frame_ack and byte_stb in the same cycle: ack wins; the byte is evaluated as in IDLE (a HEADER byte moves to CMD).
  - frame_ack outside HOLD is ignored.
- rd_data: buf[rd_addr] registered, 1-cycle latency. Returns 8'h00 if rd_addr >= frame_len or frame_valid == 0.
- frame_cmd/frame_len change only on the transition into HOLD. The buffer is not overwritten while in HOLD.
- err_pulse: exactly one cycle. err_code holds its last value between pulses.
- Async reset mid-frame: state and counters clear immediately; the partial frame is lost.

Optional Feature:
- Macro: UART_FRAME_PARSER_TIMEOUT_EN.
- Defined:
  - In CMD/LEN/DATA/CSUM, a counter increments each clk and clears on byte_stb.
  - When it reaches TIMEOUT_CYC-1: err 2'b11, go to IDLE, counter cleared.
  - Counter held at 0 in IDLE/HOLD.
- Undefined: no counter logic; a partial frame waits indefinitely. Code 2'b11 is never produced.

Decomposition:
- Package uart_frame_pkg holds:
  - FSM state enum.
  - Error code constants ERR_OVERRUN=2'b00, ERR_LEN=2'b01, ERR_CSUM=2'b10, ERR_TIMEOUT=2'b11.
  - Default HEADER constant.
- Sub-module uart_frame_buf: MAX_LEN x 8 simple dual-port RAM with one write port and one registered read port. Range masking stays in the parent.

Test Plan:
- Strobe handling: A5 03 03 11 22 33 (csum 0x6C = 03+03+11+22+33), each byte's rx_rdsig held 2 cycles -> frame_valid=1, cmd=03, len=3, rd_addr 0..2 give 11,22,33 one cycle later, no err.
- Bad checksum: A5 01 02 AA BB csum 0x00 (correct 0x68) -> err_pulse with 2'b10, frame_valid stays 0. Next good frame is accepted.
- Zero length and header hunting: garbage 00 FF 5A then A5 07 00 07 -> frame_valid, len=0, rd_data=00 at any address.
- Length limit: A5 01 11 (17 > MAX_LEN=16) -> err 2'b01, return to IDLE. Subsequent 11 bytes do not start a frame.
- Overrun and ack: with frame held, send byte 42 -> err 2'b00, frame contents unchanged. Then frame_ack coincident with strobe of A5 -> frame_valid falls, parser in CMD.
- Timeout (macro defined): A5 05 then silence 640 cycles -> err 2'b11 at cycle 640 after the last strobe. With the macro undefined, no error and the frame completes later.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame parser.
// The optional inter-byte timeout is enabled by defining UART_FRAME_PARSER_TIMEOUT_EN.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_HOLD = 3'd5
    } state_e;

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload storage: one write port, one registered read port.
// Out-of-range addresses are masked by the parent, not here.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles HEADER/CMD/LEN/payload/CSUM frames from the UART byte stream and holds
// one checked frame until acknowledged. Define UART_FRAME_PARSER_TIMEOUT_EN for the inter-byte timeout.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] HEADER      = HEADER_DEFAULT,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 640
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_rdsig,
    output logic                       frame_valid,
    output logic [7:0]                 frame_cmd,
    output logic [7:0]                 frame_len,
    input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
    output logic [7:0]                 rd_data,
    input  logic                       frame_ack,
    output logic                       err_pulse,
    output logic [1:0]                 err_code
);

    localparam int         AW        = $clog2(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e     state_q, state_d;
    logic       rdsig_q;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] len_q, len_d;
    logic [7:0] csum_q, csum_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic [7:0] fcmd_q, fcmd_d;
    logic [7:0] flen_q, flen_d;
    logic       err_pulse_q, err_pulse_d;
    logic [1:0] err_code_q, err_code_d;
    logic       mask_q, mask_d;
    logic       buf_we;
    logic [7:0] buf_rdata;
    logic       byte_stb;

    // One byte per rising edge of the receiver's ready level.
    assign byte_stb = rx_rdsig & ~rdsig_q;

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] tmo_q, tmo_d;
`else
    logic [31:0] tmo_cfg_unused;
    assign tmo_cfg_unused = TIMEOUT_CYC;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        csum_d      = csum_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        fcmd_d      = fcmd_q;
        flen_d      = flen_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        buf_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (byte_stb && rx_data == HEADER) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (byte_stb) begin
                    cmd_d   = rx_data;
                    csum_d  = rx_data;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (byte_stb) begin
                    if (rx_data > MAX_LEN_B) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = ST_IDLE;
                    end else begin
                        len_d   = rx_data;
                        csum_d  = csum_q + rx_data;
                        cnt_d   = '0;
                        state_d = (rx_data == 8'd0) ? ST_CSUM : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (byte_stb) begin
                    buf_we = 1'b1;
                    csum_d = csum_q + rx_data;
                    cnt_d  = cnt_q + 1'b1;
                    if (8'(cnt_q) == 8'(len_q - 8'd1)) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (byte_stb) begin
                    if (rx_data == csum_q) begin
                        valid_d = 1'b1;
                        fcmd_d  = cmd_q;
                        flen_d  = len_q;
                        state_d = ST_HOLD;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // An ack releases the frame first, so a coincident byte is parsed as in IDLE.
                if (frame_ack) begin
                    valid_d = 1'b0;
                    state_d = (byte_stb && rx_data == HEADER) ? ST_CMD : ST_IDLE;
                end else if (byte_stb) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        tmo_d = '0;
        if (state_q inside {ST_CMD, ST_LEN, ST_DATA, ST_CSUM} && !byte_stb) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                err_pulse_d = 1'b1;
                err_code_d  = ERR_TIMEOUT;
                state_d     = ST_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    // Read mask is captured alongside the RAM read so both line up one cycle later.
    always_comb begin
        mask_d = valid_q && (8'(rd_addr) < flen_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rdsig_q     <= 1'b0;
            cmd_q       <= '0;
            len_q       <= '0;
            csum_q      <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            fcmd_q      <= '0;
            flen_q      <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
            mask_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdsig_q     <= rx_rdsig;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            fcmd_q      <= fcmd_d;
            flen_q      <= flen_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            mask_q      <= mask_d;
        end
    end

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    uart_frame_buf #(
        .DEPTH(MAX_LEN),
        .AW   (AW)
    ) u_buf (
        .clk  (clk),
        .we   (buf_we),
        .waddr(cnt_q),
        .wdata(rx_data),
        .raddr(rd_addr),
        .rdata(buf_rdata)
    );

    assign frame_valid = valid_q;
    assign frame_cmd   = fcmd_q;
    assign frame_len   = flen_q;
    assign rd_data     = mask_q ? buf_rdata : 8'h00;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed plus randomized bench for uart_frame_parser with a frame-level reference model.
module tb_uart_frame_parser;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] HDR     = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_rdsig;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_ack;
    logic       err_pulse;
    logic [1:0] err_code;

    int checks   = 0;
    int failures = 0;

    // Reference model: frame-level view of the byte stream.
    bit         held;
    bit         in_frame;
    logic [7:0] part[$];
    logic [7:0] h_pay[$];
    logic [7:0] h_len;
    logic [7:0] out_cmd;
    logic [7:0] out_len;
    logic [1:0] last_code;

    uart_frame_parser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_rdsig   (rx_rdsig),
        .frame_valid(frame_valid),
        .frame_cmd  (frame_cmd),
        .frame_len  (frame_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_ack  (frame_ack),
        .err_pulse  (err_pulse),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        held      = 0;
        in_frame  = 0;
        part.delete();
        h_pay.delete();
        h_len     = 8'h00;
        out_cmd   = 8'h00;
        out_len   = 8'h00;
        last_code = 2'b00;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit e, output logic [1:0] c);
        int n;
        int sum;
        e = 0;
        c = 2'b00;
        if (held) begin
            e = 1;
            c = 2'b00;
            return;
        end
        if (!in_frame) begin
            if (b == HDR) begin
                in_frame = 1;
                part.delete();
            end
            return;
        end
        part.push_back(b);
        n = part.size();
        if (n == 2 && int'(part[1]) > MAX_LEN) begin
            e = 1;
            c = 2'b01;
            in_frame = 0;
            return;
        end
        if (n >= 3 && n == int'(part[1]) + 3) begin
            sum = 0;
            for (int i = 0; i < n - 1; i++) sum += int'(part[i]);
            if (sum[7:0] == b) begin
                held    = 1;
                out_cmd = part[0];
                out_len = part[1];
                h_len   = part[1];
                h_pay.delete();
                for (int i = 2; i < n - 1; i++) h_pay.push_back(part[i]);
            end else begin
                e = 1;
                c = 2'b10;
            end
            in_frame = 0;
        end
    endtask

    task automatic check_outputs(input bit e);
        chk("err_pulse", {31'd0, err_pulse}, {31'd0, e});
        chk("err_code", {30'd0, err_code}, {30'd0, last_code});
        chk("frame_valid", {31'd0, frame_valid}, {31'd0, held});
        chk("frame_cmd", {24'd0, frame_cmd}, {24'd0, out_cmd});
        chk("frame_len", {24'd0, frame_len}, {24'd0, out_len});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ack, input int hold, input int gap);
        bit e;
        logic [1:0] c;
        @(negedge clk);
        rx_data   = b;
        rx_rdsig  = 1'b1;
        frame_ack = ack;
        if (ack) held = 0;
        model_byte(b, e, c);
        if (e) last_code = c;
        @(negedge clk);
        frame_ack = 1'b0;
        check_outputs(e);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chk("err_pulse_single", {31'd0, err_pulse}, 32'd0);
        end
        rx_rdsig = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_list(input logic [7:0] bl[$]);
        foreach (bl[i]) send_byte(bl[i], 1'b0, 2, 1);
    endtask

    task automatic check_read(input int a);
        logic [7:0] exp;
        @(negedge clk);
        rd_addr = 4'(a);
        @(negedge clk);
        exp = (held && a < int'(h_len)) ? h_pay[a] : 8'h00;
        chk($sformatf("rd_data[%0d]", a), {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic do_ack();
        @(negedge clk);
        frame_ack = 1'b1;
        held = 0;
        @(negedge clk);
        frame_ack = 1'b0;
        check_outputs(1'b0);
    endtask

    initial begin
        int k;
        int seen;
        logic [7:0] len;
        logic [7:0] cmd;
        logic [7:0] sum;
        logic [7:0] bl[$];

        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_rdsig  = 1'b0;
        rd_addr   = 4'd0;
        frame_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs(1'b0);
        chk("rd_data_reset", {24'd0, rd_data}, 32'd0);
        rst_n = 1'b1;

        // Good frame with level held two cycles per byte.
        send_list('{8'hA5, 8'h03, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6C});
        for (int a = 0; a < 4; a++) check_read(a);

        // Overrun while held, then ack coincident with a new header.
        send_byte(8'h42, 1'b0, 2, 1);
        for (int a = 0; a < 3; a++) check_read(a);
        send_byte(HDR, 1'b1, 2, 1);
        send_list('{8'h09, 8'h01, 8'h77, 8'h81});
        check_read(0);
        check_read(1);
        do_ack();
        check_read(0);

        // Bad checksum, then the same frame with the right one.
        send_list('{8'hA5, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'h00});
        send_list('{8'hA5, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'h68});
        check_read(1);
        do_ack();

        // Header hunting and zero-length frame.
        send_list('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h07, 8'h00, 8'h07});
        check_read(0);
        check_read(5);
        check_read(15);
        do_ack();

        // Over-length LEN, then stray bytes must not start a frame.
        send_list('{8'hA5, 8'h01, 8'h11, 8'h11, 8'h11, 8'h11});

        // Ack with nothing held is harmless.
        do_ack();

        // Asynchronous reset mid-frame loses the partial frame.
        send_list('{8'hA5, 8'h03});
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs(1'b0);
        rst_n = 1'b1;
        send_list('{8'hA5, 8'h04, 8'h01, 8'h5A, 8'h5F});
        check_read(0);
        do_ack();

        // Silence after a partial frame.
        send_list('{8'hA5});
        @(negedge clk);
        rx_data  = 8'h05;
        rx_rdsig = 1'b1;
        begin
            bit e;
            logic [1:0] c;
            model_byte(8'h05, e, c);
        end
        @(negedge clk);
        rx_rdsig = 1'b0;
        seen = 0;
        for (k = 1; k <= 700; k++) begin
            @(negedge clk);
            if (err_pulse && seen == 0) seen = k;
        end
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        chk("timeout_cycle", seen, 640);
        chk("timeout_code", {30'd0, err_code}, 32'd3);
        last_code = 2'b11;
        in_frame  = 0;
`else
        chk("no_timeout", seen, 0);
`endif
        send_list('{8'h01, 8'h09, 8'h0F});
        check_read(0);
        do_ack();

        // Randomized frames with garbage, bad lengths, bad checksums, overruns.
        for (int f = 0; f < 40; f++) begin
            bl.delete();
            repeat ($urandom_range(0, 3)) bl.push_back(8'($urandom_range(0, 255)));
            bl.push_back(HDR);
            cmd = 8'($urandom_range(0, 255));
            len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(17, 255))
                                               : 8'($urandom_range(0, MAX_LEN));
            bl.push_back(cmd);
            bl.push_back(len);
            if (int'(len) <= MAX_LEN) begin
                sum = cmd + len;
                for (int i = 0; i < int'(len); i++) begin
                    bl.push_back(8'($urandom_range(0, 255)));
                    sum = sum + bl[bl.size() - 1];
                end
                if ($urandom_range(0, 3) == 0) sum = sum ^ 8'(1 << $urandom_range(0, 7));
                bl.push_back(sum);
            end
            foreach (bl[i]) send_byte(bl[i], 1'b0, $urandom_range(1, 3), $urandom_range(0, 2));
            if (held) begin
                repeat (3) check_read($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) send_byte(8'($urandom_range(0, 255)), 1'b0, 1, 1);
                check_read($urandom_range(0, int'(h_len)));
                if ($urandom_range(0, 1) == 0) send_byte(HDR, 1'b1, 1, 1);
                else do_ack();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
